// File: rtl/fetch_stage.sv
// fetch_stage: word-address PC, one-outstanding imem request, registered inst/pc to decode with stall hold and redirect flush
module fetch_stage #(
    parameter logic [29:0] RESET_PC = 30'h0000_0000
) (
    input  logic        clk,
    input  logic        sync_rst,
    input  logic        clk_en,
    input  logic        redirect,
    input  logic [29:0] redirect_pc,
    output logic [29:0] imem_addr,
    output logic        imem_req,
    input  logic [31:0] imem_data,
    input  logic        imem_valid,
    output logic [31:0] inst_out,
    output logic [29:0] pc_out
);
    localparam logic [31:0] NOP = 32'h0000_0013;
    typedef enum logic [1:0] {FETCH, HOLD, DISCARD} state_t;
    state_t      state;
    logic [29:0] fetch_addr;
    logic [29:0] target;
    logic [29:0] hold_pc;
    logic [31:0] hold_inst;
    logic        take;
    assign imem_req  = state == FETCH || state == DISCARD;
    assign imem_addr = fetch_addr;
    assign take      = imem_valid && imem_req;
    always_ff @(posedge clk) begin
        if (sync_rst) begin
            state      <= FETCH;
            fetch_addr <= RESET_PC;
            target     <= RESET_PC;
            inst_out   <= NOP;
            pc_out     <= RESET_PC;
            hold_inst  <= NOP;
            hold_pc    <= RESET_PC;
        end else if (redirect) begin
            inst_out <= NOP;
            target   <= redirect_pc;
            if (state == HOLD || take) begin
                fetch_addr <= redirect_pc;
                state      <= FETCH;
            end else begin
                state <= DISCARD;
            end
        end else begin
            case (state)
                FETCH: begin
                    if (take) begin
                        fetch_addr <= fetch_addr + 30'd1;
                        if (clk_en) begin
                            inst_out <= imem_data;
                            pc_out   <= fetch_addr;
                        end else begin
                            hold_inst <= imem_data;
                            hold_pc   <= fetch_addr;
                            state     <= HOLD;
                        end
                    end else if (clk_en) begin
                        inst_out <= NOP;
                    end
                end
                HOLD: begin
                    if (clk_en) begin
                        inst_out <= hold_inst;
                        pc_out   <= hold_pc;
                        state    <= FETCH;
                    end
                end
                DISCARD: begin
                    if (take) begin
                        fetch_addr <= target;
                        state      <= FETCH;
                    end
                    if (clk_en) inst_out <= NOP;
                end
                default: state <= FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed stimulus with a latency-programmable memory model and an output scoreboard
module tb_fetch_stage;
    localparam logic [31:0] NOP = 32'h0000_0013;
    typedef struct packed {logic [31:0] inst; logic [29:0] pc;} exp_t;
    logic        clk = 0;
    logic        sync_rst = 1;
    logic        clk_en = 1;
    logic        redirect = 0;
    logic [29:0] redirect_pc = '0;
    logic [29:0] imem_addr;
    logic        imem_req;
    logic [31:0] imem_data = '0;
    logic        imem_valid = 0;
    logic [31:0] inst_out;
    logic [29:0] pc_out;
    int          checks = 0;
    int          failures = 0;
    int          lat = 1;
    int          mem_cnt = 0;
    logic [29:0] mem_last = '0;
    logic        mon_adv;
    exp_t        mon_e;
    exp_t        q[$];

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(30'h0)) dut (
        .clk(clk), .sync_rst(sync_rst), .clk_en(clk_en), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_addr(imem_addr), .imem_req(imem_req),
        .imem_data(imem_data), .imem_valid(imem_valid), .inst_out(inst_out), .pc_out(pc_out)
    );

    function automatic logic [31:0] word(input logic [29:0] a);
        return {2'b10, a};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [29:0] a);
        q.push_back({word(a), a});
    endtask

    task automatic wait_for(input logic [29:0] a, input bit need_valid);
        bit found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            if (imem_addr == a && (!need_valid || imem_valid)) found = 1;
            else @(negedge clk);
        end
        if (!found) begin
            checks++;
            failures++;
            $display("FAIL wait_addr: got %h expected %h", imem_addr, a);
        end
    endtask

    // memory: responds once the same address has been requested for lat cycles
    initial forever begin
        @(posedge clk);
        #1;
        if (sync_rst || !imem_req || imem_valid || imem_addr != mem_last) mem_cnt = 0;
        imem_valid = 0;
        mem_last = imem_addr;
        if (!sync_rst && imem_req) begin
            mem_cnt++;
            if (mem_cnt >= lat) begin
                imem_valid = 1;
                imem_data = word(imem_addr);
            end
        end
    end

    initial forever begin
        @(posedge clk);
        mon_adv = clk_en && !redirect && !sync_rst;
        #2;
        if (mon_adv && inst_out != NOP) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_out: got %h pc %h expected none", inst_out, pc_out);
            end else begin
                mon_e = q.pop_front();
                chk("sb_inst", inst_out, mon_e.inst);
                chk("sb_pc", {2'b0, pc_out}, {2'b0, mon_e.pc});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_inst", inst_out, NOP);
        chk("rst_pc", {2'b0, pc_out}, 32'h0);
        chk("rst_addr", {2'b0, imem_addr}, 32'h0);
        chk("rst_req", {31'b0, imem_req}, 32'h1);
        for (int a = 0; a < 6; a++) push(a[29:0]);
        sync_rst = 0;
        @(negedge clk);
        chk("first_nop", inst_out, NOP);
        @(negedge clk);
        chk("seq0", inst_out, word(30'd0));
        @(negedge clk);
        chk("seq1", inst_out, word(30'd1));
        @(negedge clk);
        chk("seq2", inst_out, word(30'd2));
        wait_for(30'd5, 1);
        clk_en = 0;
        repeat (3) begin
            @(negedge clk);
            chk("hold_req", {31'b0, imem_req}, 32'h0);
            chk("hold_addr", {2'b0, imem_addr}, 32'd6);
            chk("hold_inst", inst_out, word(30'd4));
        end
        clk_en = 1;
        lat = 3;
        push(30'd6);
        @(negedge clk);
        chk("unhold_inst", inst_out, word(30'd5));
        chk("unhold_pc", {2'b0, pc_out}, 32'd5);
        wait_for(30'd7, 0);
        redirect = 1;
        redirect_pc = 30'h100;
        push(30'h100);
        @(negedge clk);
        redirect = 0;
        chk("redir_nop", inst_out, NOP);
        chk("disc_addr_a", {2'b0, imem_addr}, 32'd7);
        chk("disc_req", {31'b0, imem_req}, 32'h1);
        @(negedge clk);
        chk("disc_addr_b", {2'b0, imem_addr}, 32'd7);
        wait_for(30'h100, 0);
        wait_for(30'h101, 1);
        redirect = 1;
        redirect_pc = 30'h200;
        push(30'h200);
        @(negedge clk);
        redirect = 0;
        chk("same_cyc_addr", {2'b0, imem_addr}, 32'h200);
        wait_for(30'h201, 0);
        redirect = 1;
        redirect_pc = 30'h40;
        @(negedge clk);
        redirect_pc = 30'h80;
        @(negedge clk);
        redirect = 0;
        push(30'h80);
        wait_for(30'h80, 0);
        wait_for(30'h81, 0);
        redirect = 1;
        redirect_pc = 30'h3FFF_FFFF;
        push(30'h3FFF_FFFF);
        push(30'h0);
        @(negedge clk);
        redirect = 0;
        wait_for(30'h3FFF_FFFF, 0);
        wait_for(30'h0, 0);
        chk("wrap_addr", {2'b0, imem_addr}, 32'h0);
        wait_for(30'h1, 0);
        redirect = 1;
        redirect_pc = 30'h300;
        @(negedge clk);
        redirect = 0;
        sync_rst = 1;
        lat = 1;
        @(negedge clk);
        chk("mid_rst_addr", {2'b0, imem_addr}, 32'h0);
        chk("mid_rst_inst", inst_out, NOP);
        chk("mid_rst_pc", {2'b0, pc_out}, 32'h0);
        chk("mid_rst_req", {31'b0, imem_req}, 32'h1);
        for (int a = 0; a < 3; a++) push(a[29:0]);
        sync_rst = 0;
        wait_for(30'd3, 0);
        sync_rst = 1;
        repeat (3) @(negedge clk);
        chk("sb_drained", q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
